// File: rtl/wb_fabric_pkg.sv
// Shared definitions for the two-master Wishbone fabric arbiter:
// arbiter states, bus bundle widths and the timeout read value.
package wb_fabric_pkg;

    localparam int WB_ADDR_WIDTH = 17;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_BSTB_WIDTH = 4;

    localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_timeout_cntr.sv
// Bus watchdog counter: counts enabled cycles after a clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES-1.
module wb_timeout_cntr #(
    parameter int CNTR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNTR_WIDTH-1:0] count;

    assign expired = (count == CNTR_WIDTH'(TIMEOUT_CYCLES - 1));

    // Holds at the terminal value so a stalled owner cannot wrap the count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNTR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/wb_fabric_arbiter.sv
// Round-robin arbiter giving two Wishbone masters alternating access to the
// FPGA IP slave bus, with a watchdog that force-completes hung transfers.
module wb_fabric_arbiter
    import wb_fabric_pkg::*;
#(
    parameter int ADDRWIDTH      = WB_ADDR_WIDTH,
    parameter int DATAWIDTH      = WB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNTR_WIDTH     = 8,
    parameter logic [DATAWIDTH-1:0] DEFAULT_READ_VALUE = wb_fabric_pkg::DEFAULT_READ_VALUE
) (
    input  logic                     WBs_CLK_i,
    input  logic                     WBs_RST_i,

    input  logic [ADDRWIDTH-1:0]     M0_ADR_i,
    input  logic                     M0_CYC_i,
    input  logic                     M0_STB_i,
    input  logic                     M0_WE_i,
    input  logic                     M0_RD_i,
    input  logic [WB_BSTB_WIDTH-1:0] M0_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0]     M0_DAT_i,
    output logic [DATAWIDTH-1:0]     M0_DAT_o,
    output logic                     M0_ACK_o,

    input  logic [ADDRWIDTH-1:0]     M1_ADR_i,
    input  logic                     M1_CYC_i,
    input  logic                     M1_STB_i,
    input  logic                     M1_WE_i,
    input  logic                     M1_RD_i,
    input  logic [WB_BSTB_WIDTH-1:0] M1_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0]     M1_DAT_i,
    output logic [DATAWIDTH-1:0]     M1_DAT_o,
    output logic                     M1_ACK_o,

    output logic [ADDRWIDTH-1:0]     S_ADR_o,
    output logic                     S_CYC_o,
    output logic                     S_STB_o,
    output logic                     S_WE_o,
    output logic                     S_RD_o,
    output logic [WB_BSTB_WIDTH-1:0] S_BYTE_STB_o,
    output logic [DATAWIDTH-1:0]     S_DAT_o,
    input  logic [DATAWIDTH-1:0]     S_DAT_i,
    input  logic                     S_ACK_i,

    output logic [1:0]               Grant_o,
    output logic                     Timeout_o
);

    arb_state_t state;
    logic       last_owner;
    logic       owned;
    logic       own_sel;
    logic       own_cyc;
    logic       own_stb;
    logic       req0;
    logic       req1;
    logic       expired;
    logic       timeout_hit;

    assign req0    = M0_CYC_i & M0_STB_i;
    assign req1    = M1_CYC_i & M1_STB_i;
    assign owned   = (state == ST_OWN0) || (state == ST_OWN1);
    assign own_sel = (state == ST_OWN1);
    assign own_cyc = own_sel ? M1_CYC_i : M0_CYC_i;
    assign own_stb = own_sel ? M1_STB_i : M0_STB_i;

    // A real slave ACK in the terminal cycle wins; a dropped CYC is an abort, not a timeout.
    assign timeout_hit = owned && expired && !S_ACK_i && own_cyc;
    assign Timeout_o   = timeout_hit;

    wb_timeout_cntr #(
        .CNTR_WIDTH    (CNTR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cntr (
        .clk    (WBs_CLK_i),
        .reset  (WBs_RST_i),
        .clear  (!owned),
        .enable (owned && !S_ACK_i),
        .expired(expired)
    );

    // Every release passes through IDLE, so contention alternates owners.
    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
            Grant_o    <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 && (!req1 || last_owner)) begin
                        state   <= ST_OWN0;
                        Grant_o <= 2'b01;
                    end else if (req1) begin
                        state   <= ST_OWN1;
                        Grant_o <= 2'b10;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (S_ACK_i || timeout_hit || !own_cyc) begin
                        state      <= ST_IDLE;
                        Grant_o    <= 2'b00;
                        last_owner <= own_sel;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    Grant_o <= 2'b00;
                end
            endcase
        end
    end

    // Request mux toward the slaves and ACK/data demux back to the owner only.
    always_comb begin
        S_ADR_o      = '0;
        S_CYC_o      = 1'b0;
        S_STB_o      = 1'b0;
        S_WE_o       = 1'b0;
        S_RD_o       = 1'b0;
        S_BYTE_STB_o = '0;
        S_DAT_o      = '0;
        M0_ACK_o     = 1'b0;
        M0_DAT_o     = '0;
        M1_ACK_o     = 1'b0;
        M1_DAT_o     = '0;
        if (owned) begin
            S_ADR_o      = own_sel ? M1_ADR_i      : M0_ADR_i;
            S_WE_o       = own_sel ? M1_WE_i       : M0_WE_i;
            S_RD_o       = own_sel ? M1_RD_i       : M0_RD_i;
            S_BYTE_STB_o = own_sel ? M1_BYTE_STB_i : M0_BYTE_STB_i;
            S_DAT_o      = own_sel ? M1_DAT_i      : M0_DAT_i;
            S_CYC_o      = own_cyc && !timeout_hit;
            S_STB_o      = own_stb && !timeout_hit;
        end
        if (state == ST_OWN0) begin
            M0_ACK_o = S_ACK_i || timeout_hit;
            M0_DAT_o = timeout_hit ? DEFAULT_READ_VALUE : S_DAT_i;
        end
        if (state == ST_OWN1) begin
            M1_ACK_o = S_ACK_i || timeout_hit;
            M1_DAT_o = timeout_hit ? DEFAULT_READ_VALUE : S_DAT_i;
        end
    end

endmodule

// File: tb/tb_wb_fabric_arbiter.sv
// Directed plus randomized bench for wb_fabric_arbiter, compared every cycle
// against a transaction-level reference model of the arbitration rules.
module tb_wb_fabric_arbiter;
    import wb_fabric_pkg::*;

    localparam int TO = 8;

    logic        WBs_CLK_i = 1'b0;
    logic        WBs_RST_i;
    logic [16:0] M0_ADR_i, M1_ADR_i, S_ADR_o;
    logic        M0_CYC_i, M0_STB_i, M0_WE_i, M0_RD_i;
    logic        M1_CYC_i, M1_STB_i, M1_WE_i, M1_RD_i;
    logic [3:0]  M0_BYTE_STB_i, M1_BYTE_STB_i, S_BYTE_STB_o;
    logic [31:0] M0_DAT_i, M1_DAT_i, M0_DAT_o, M1_DAT_o, S_DAT_o, S_DAT_i;
    logic        M0_ACK_o, M1_ACK_o, S_CYC_o, S_STB_o, S_WE_o, S_RD_o, S_ACK_i;
    logic [1:0]  Grant_o;
    logic        Timeout_o;

    always #5 WBs_CLK_i = ~WBs_CLK_i;

    wb_fabric_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .WBs_CLK_i(WBs_CLK_i), .WBs_RST_i(WBs_RST_i),
        .M0_ADR_i(M0_ADR_i), .M0_CYC_i(M0_CYC_i), .M0_STB_i(M0_STB_i), .M0_WE_i(M0_WE_i),
        .M0_RD_i(M0_RD_i), .M0_BYTE_STB_i(M0_BYTE_STB_i), .M0_DAT_i(M0_DAT_i),
        .M0_DAT_o(M0_DAT_o), .M0_ACK_o(M0_ACK_o),
        .M1_ADR_i(M1_ADR_i), .M1_CYC_i(M1_CYC_i), .M1_STB_i(M1_STB_i), .M1_WE_i(M1_WE_i),
        .M1_RD_i(M1_RD_i), .M1_BYTE_STB_i(M1_BYTE_STB_i), .M1_DAT_i(M1_DAT_i),
        .M1_DAT_o(M1_DAT_o), .M1_ACK_o(M1_ACK_o),
        .S_ADR_o(S_ADR_o), .S_CYC_o(S_CYC_o), .S_STB_o(S_STB_o), .S_WE_o(S_WE_o),
        .S_RD_o(S_RD_o), .S_BYTE_STB_o(S_BYTE_STB_o), .S_DAT_o(S_DAT_o),
        .S_DAT_i(S_DAT_i), .S_ACK_i(S_ACK_i),
        .Grant_o(Grant_o), .Timeout_o(Timeout_o)
    );

    // Stimulus intent for the coming cycle.
    logic        rst_v;
    logic [1:0]  cyc_v, stb_v, we_v, rd_v, once_v;
    logic [16:0] adr_v [2];
    logic [3:0]  bstb_v [2];
    logic [31:0] wdat_v [2];
    int          ack_delay;
    bit          random_ack, fixed_sdat;
    logic [31:0] sdat_val;
    int          s_run;

    // Reference model: who holds the bus, how many granted cycles have elapsed, who went last.
    int mdl_owner, mdl_cnt, mdl_last;

    int          n_vectors, n_miscompares;
    int          ack_cnt [2];
    int          tmo_cnt;
    logic [1:0]  last_grant, last_ack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vectors++;
        assert (obs === expv) else begin
            n_miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus();
        @(negedge WBs_CLK_i);
        WBs_RST_i = rst_v;
        M0_CYC_i = cyc_v[0]; M0_STB_i = stb_v[0]; M0_WE_i = we_v[0]; M0_RD_i = rd_v[0];
        M0_ADR_i = adr_v[0]; M0_BYTE_STB_i = bstb_v[0]; M0_DAT_i = wdat_v[0];
        M1_CYC_i = cyc_v[1]; M1_STB_i = stb_v[1]; M1_WE_i = we_v[1]; M1_RD_i = rd_v[1];
        M1_ADR_i = adr_v[1]; M1_BYTE_STB_i = bstb_v[1]; M1_DAT_i = wdat_v[1];
        S_DAT_i = fixed_sdat ? sdat_val : $urandom;
        S_ACK_i = 1'b0;
        #1;
        if (random_ack) S_ACK_i = ($urandom_range(0, 5) == 0);
        else            S_ACK_i = (Grant_o != 2'b00) && (ack_delay >= 0) && (s_run == ack_delay);
        #1;
    endtask

    task automatic checkOutput();
        logic [1:0]  e_grant;
        logic        e_tmo, e_ack0, e_ack1, e_cyc, e_stb, e_we, e_rd;
        logic [31:0] e_dat0, e_dat1, e_sdat;
        logic [16:0] e_adr;
        logic [3:0]  e_bstb;
        logic        r0, r1;
        e_grant = 2'b00; e_tmo = 0; e_ack0 = 0; e_ack1 = 0; e_cyc = 0; e_stb = 0;
        e_we = 0; e_rd = 0; e_dat0 = 0; e_dat1 = 0; e_sdat = 0; e_adr = 0; e_bstb = 0;
        if (mdl_owner >= 0) begin
            e_grant = (mdl_owner == 0) ? 2'b01 : 2'b10;
            e_tmo   = (mdl_cnt + 1 == TO) && !S_ACK_i && cyc_v[mdl_owner];
            e_adr   = adr_v[mdl_owner];
            e_we    = we_v[mdl_owner];
            e_rd    = rd_v[mdl_owner];
            e_bstb  = bstb_v[mdl_owner];
            e_sdat  = wdat_v[mdl_owner];
            e_cyc   = cyc_v[mdl_owner] && !e_tmo;
            e_stb   = stb_v[mdl_owner] && !e_tmo;
            if (mdl_owner == 0) begin
                e_ack0 = S_ACK_i || e_tmo;
                e_dat0 = e_tmo ? 32'hBADFABAC : S_DAT_i;
            end else begin
                e_ack1 = S_ACK_i || e_tmo;
                e_dat1 = e_tmo ? 32'hBADFABAC : S_DAT_i;
            end
        end
        chk("grant", Grant_o, e_grant);
        chk("timeout", Timeout_o, e_tmo);
        chk("m0_ack", M0_ACK_o, e_ack0);
        chk("m1_ack", M1_ACK_o, e_ack1);
        chk("m0_dat", M0_DAT_o, e_dat0);
        chk("m1_dat", M1_DAT_o, e_dat1);
        chk("s_cyc", S_CYC_o, e_cyc);
        chk("s_stb", S_STB_o, e_stb);
        chk("s_we", S_WE_o, e_we);
        chk("s_rd", S_RD_o, e_rd);
        chk("s_adr", S_ADR_o, e_adr);
        chk("s_bstb", S_BYTE_STB_o, e_bstb);
        chk("s_dat", S_DAT_o, e_sdat);
        if (M0_ACK_o) ack_cnt[0]++;
        if (M1_ACK_o) ack_cnt[1]++;
        if (Timeout_o) tmo_cnt++;
        last_grant = Grant_o;
        last_ack   = {M1_ACK_o, M0_ACK_o};
        if (rst_v) begin
            mdl_owner = -1; mdl_last = 1; mdl_cnt = 0;
        end else if (mdl_owner < 0) begin
            r0 = cyc_v[0] && stb_v[0];
            r1 = cyc_v[1] && stb_v[1];
            mdl_cnt = 0;
            if (r0 && r1)  mdl_owner = 1 - mdl_last;
            else if (r0)   mdl_owner = 0;
            else if (r1)   mdl_owner = 1;
        end else if (S_ACK_i || e_tmo || !cyc_v[mdl_owner]) begin
            mdl_last  = mdl_owner;
            mdl_owner = -1;
        end else begin
            mdl_cnt++;
        end
        for (int x = 0; x < 2; x++)
            if (once_v[x] && last_ack[x]) begin cyc_v[x] = 0; stb_v[x] = 0; end
        s_run = (rst_v || Grant_o == 2'b00) ? 0 : s_run + 1;
    endtask

    task automatic runCycle();
        applyStimulus();
        checkOutput();
    endtask

    task automatic idleMasters();
        cyc_v = 0; stb_v = 0; we_v = 0; rd_v = 0; once_v = 0;
        for (int x = 0; x < 2; x++) begin
            adr_v[x] = 0; bstb_v[x] = 0; wdat_v[x] = 0;
        end
    endtask

    task automatic doReset();
        idleMasters();
        rst_v = 1; runCycle(); rst_v = 0;
        ack_cnt[0] = 0; ack_cnt[1] = 0; tmo_cnt = 0;
    endtask

    initial begin
        int glog [12];
        int gcount, ack_at;
        WBs_RST_i = 1; S_ACK_i = 0; S_DAT_i = 0;
        {M0_CYC_i, M0_STB_i, M0_WE_i, M0_RD_i, M1_CYC_i, M1_STB_i, M1_WE_i, M1_RD_i} = '0;
        M0_ADR_i = 0; M1_ADR_i = 0; M0_BYTE_STB_i = 0; M1_BYTE_STB_i = 0; M0_DAT_i = 0; M1_DAT_i = 0;
        n_vectors = 0; n_miscompares = 0; s_run = 0;
        mdl_owner = -1; mdl_cnt = 0; mdl_last = 1;
        random_ack = 0; fixed_sdat = 0; sdat_val = 0; ack_delay = -1;
        idleMasters();
        rst_v = 1;
        runCycle();
        doReset();

        // Single M0 read, slave answers on the third granted cycle.
        adr_v[0] = 17'h01000; rd_v[0] = 1; bstb_v[0] = 4'hF;
        cyc_v[0] = 1; stb_v[0] = 1; once_v[0] = 1;
        fixed_sdat = 1; sdat_val = 32'h0000_0041; ack_delay = 2;
        for (int i = 0; i < 8; i++) runCycle();
        chk("t1_m0_acks", ack_cnt[0], 1);
        chk("t1_m1_acks", ack_cnt[1], 0);

        // Contention from reset with immediate re-requests: strict alternation.
        doReset();
        fixed_sdat = 0; ack_delay = 1;
        cyc_v = 2'b11; stb_v = 2'b11; adr_v[1] = 17'h00200; we_v[1] = 1; wdat_v[1] = 32'h5555_AAAA;
        for (int i = 0; i < 12; i++) begin runCycle(); glog[i] = int'(last_grant); end
        begin
            int expg [12] = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2};
            for (int i = 0; i < 12; i++) chk($sformatf("t2_grant_c%0d", i), glog[i], expg[i]);
        end

        // M1 write with a silent slave, then with an ACK exactly on the last cycle.
        for (int pass = 0; pass < 2; pass++) begin
            doReset();
            adr_v[1] = 17'h04000; we_v[1] = 1; bstb_v[1] = 4'hF; wdat_v[1] = $urandom;
            cyc_v[1] = 1; stb_v[1] = 1; once_v[1] = 1;
            ack_delay = (pass == 0) ? -1 : TO - 1;
            gcount = 0; ack_at = 0;
            for (int i = 0; i < 14; i++) begin
                runCycle();
                if (last_grant == 2'b10) gcount++;
                if (last_ack[1]) ack_at = gcount;
            end
            chk($sformatf("t3_ack_cycle_p%0d", pass), ack_at, TO);
            chk($sformatf("t3_timeouts_p%0d", pass), tmo_cnt, (pass == 0) ? 1 : 0);
            chk($sformatf("t3_m1_acks_p%0d", pass), ack_cnt[1], 1);
        end

        // M0 aborts after three granted cycles while M1 waits.
        doReset();
        ack_delay = -1;
        cyc_v = 2'b11; stb_v = 2'b11; once_v = 2'b10;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) begin cyc_v[0] = 0; stb_v[0] = 0; end
            runCycle();
            glog[i] = int'(last_grant);
        end
        begin
            int expa [7] = '{0, 1, 1, 1, 1, 0, 2};
            for (int i = 0; i < 7; i++) chk($sformatf("t5_grant_c%0d", i), glog[i], expa[i]);
        end
        chk("t5_m0_acks", ack_cnt[0], 0);
        for (int i = 0; i < 10; i++) runCycle();

        // Reset in the middle of an M0 transfer, then a fresh tie.
        doReset();
        cyc_v[0] = 1; stb_v[0] = 1;
        for (int i = 0; i < 3; i++) runCycle();
        rst_v = 1; runCycle(); rst_v = 0;
        cyc_v = 2'b11; stb_v = 2'b11;
        runCycle();
        chk("t6_grant_after_rst", last_grant, 2'b00);
        runCycle();
        chk("t6_first_tie", last_grant, 2'b01);
        chk("t6_no_acks", ack_cnt[0] + ack_cnt[1], 0);

        // Randomized traffic with a randomly responding slave.
        doReset();
        random_ack = 1;
        for (int i = 0; i < 600; i++) begin
            for (int x = 0; x < 2; x++) begin
                if ($urandom_range(0, 9) == 0) cyc_v[x] = ~cyc_v[x];
                stb_v[x]  = ($urandom_range(0, 5) != 0);
                we_v[x]   = 1'($urandom_range(0, 1));
                rd_v[x]   = 1'($urandom_range(0, 1));
                adr_v[x]  = 17'($urandom);
                bstb_v[x] = 4'($urandom);
                wdat_v[x] = $urandom;
            end
            rst_v = ($urandom_range(0, 149) == 0);
            runCycle();
        end
        rst_v = 0;

        $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/wb_fabric_arbiter.md
Name: wb_fabric_arbiter

Overview:
- Two-master Wishbone arbiter in front of the FPGA IP slave bus. Master 0 is the AHB-to-FPGA bridge; master 1 is a fabric-internal master such as a future DMA or sensor sequencer.
- Grants the shared slave bus (register block, UART, GPIO, reserved block) to one master per transfer, using round-robin priority.
- Routes the slave ACK and read data back to the owning master only.
- A bus-timeout watchdog completes hung transfers with a default read value, so the slave bus cannot lock up.

Parameters:
ADDRWIDTH, 17, Wishbone byte-address width
DATAWIDTH, 32, data bus width
TIMEOUT_CYCLES, 255, granted cycles without slave ACK before the arbiter forces completion; legal range 2..2^CNTR_WIDTH-1
CNTR_WIDTH, 8, timeout counter width
DEFAULT_READ_VALUE, 32'hBAD_FAB_AC, read data returned on a timeout ACK

Ports:
WBs_CLK_i  in  1  Wishbone clock, the only clock
WBs_RST_i  in  1  synchronous active-high reset
Mx_ADR_i  in  ADDRWIDTH  master x address (x=0,1; same for all Mx_ lines)
Mx_CYC_i  in  1  master x cycle
Mx_STB_i  in  1  master x strobe
Mx_WE_i  in  1  master x write enable
Mx_RD_i  in  1  master x read enable
Mx_BYTE_STB_i  in  4  master x byte strobes
Mx_DAT_i  in  DATAWIDTH  master x write data
Mx_DAT_o  out  DATAWIDTH  master x read data
Mx_ACK_o  out  1  master x acknowledge
S_ADR_o, S_CYC_o, S_STB_o, S_WE_o, S_RD_o, S_BYTE_STB_o, S_DAT_o  out  as master  muxed slave-side request
S_DAT_i  in  DATAWIDTH  slave read data
S_ACK_i  in  1  combined slave ACK
Grant_o  out  2  one-hot current owner; 00 when idle
Timeout_o  out  1  one-cycle pulse when a forced completion occurs

Behaviour:
- Reset values:
  - Grant_o=00, Timeout_o=0, M0_ACK_o=M1_ACK_o=0, S_CYC_o=S_STB_o=0.
  - Mx_DAT_o=0 and S_* data/address=0 while idle.
  - last_owner=1, so master 0 wins the first tie.
- State machine: IDLE, OWN0, OWN1.
  - Request: reqx = Mx_CYC_i & Mx_STB_i.
  - IDLE with only reqx set: go to OWNx.
  - IDLE with both set: go to OWN(~last_owner).
  - IDLE with none set: stay in IDLE.
  - Grant is registered, so arbitration latency is 1 cycle. A request first seen in cycle N drives S_CYC_o in cycle N+1.
- OWNx datapath:
  - S_* outputs mirror master x inputs combinationally.
  - Mx_ACK_o = S_ACK_i and Mx_DAT_o = S_DAT_i, same cycle.
  - The other master sees ACK=0 and DAT=0.
- Release:
  - On S_ACK_i in OWNx: next state IDLE, last_owner<=x.
  - Every transfer costs at least one IDLE cycle, which enforces alternation under contention.
  - A master can never receive two ACKs per grant.
- Abort: Mx_CYC_i dropping while in OWNx (no ACK) moves to IDLE next cycle, sets last_owner<=x, and gives no ACK.
- Timeout:
  - The counter clears on entry to OWNx and increments each OWNx cycle without S_ACK_i.
  - In the cycle the count equals TIMEOUT_CYCLES-1, and only if S_ACK_i=0:
    - Mx_ACK_o=1 and Mx_DAT_o=DEFAULT_READ_VALUE.
    - S_CYC_o=S_STB_o=0.
    - Timeout_o=1.
    - Next state IDLE.
  - Net effect: the forced ACK is in the TIMEOUT_CYCLES-th granted cycle.
  - S_ACK_i in the same cycle wins: normal completion, no Timeout_o.
- Stale requests: requests from the non-owner are ignored while owned; the non-owner's ACK stays 0.
- Reset mid-transfer: synchronous return to IDLE with all outputs at reset values in the next cycle. No ACK is generated for the aborted transfer.
- Master 0 (bridge) semantics: S_RD_o and S_BYTE_STB_o pass through unmodified; address decode stays in the slaves.

Decomposition:
- Shared package wb_fabric_pkg:
  - state encoding enum (IDLE, OWN0, OWN1);
  - DEFAULT_READ_VALUE;
  - the Wishbone request bundle widths (17-bit address, 32-bit data, 4 byte strobes).
- One sub-module, wb_timeout_cntr: counter with clear/enable/expired, parameterised by CNTR_WIDTH and TIMEOUT_CYCLES. It is reusable by the reserved-block default-ACK logic.
- Request mux and ACK demux stay inline.

Test Plan:
- Single M0 read, address 17'h01000, slave ACKs 2 cycles after S_CYC_o:
  - S_CYC_o rises 1 cycle after the request; Grant_o=01;
  - M0_ACK_o for exactly 1 cycle with S_DAT_i=32'h0000_0041;
  - M1_ACK_o stays 0.
- M0 and M1 request in the same cycle from reset, each slave ACK 1 cycle after grant, both re-request immediately:
  - grant order 01, 10, 01, 10;
  - exactly one IDLE cycle between grants.
- M1 write to 17'h04000 with no slave ACK, TIMEOUT_CYCLES=8:
  - M1_ACK_o asserted in the 8th granted cycle with M1_DAT_o=32'hBAD_FAB_AC;
  - Timeout_o pulses once; next state IDLE.
- S_ACK_i arrives exactly in the 8th granted cycle (TIMEOUT_CYCLES=8):
  - M1_DAT_o = S_DAT_i; Timeout_o=0.
- M0 drops CYC 3 cycles after grant with no ACK:
  - Grant_o returns to 00 the next cycle, no ACK generated;
  - a pending M1 request is granted after that.
- WBs_RST_i asserted for 1 cycle during an OWN0 transfer:
  - the cycle after reset: Grant_o=00, S_CYC_o=0, no ACK to either master;
  - the first post-reset contention goes to M0.
